invaders_sound_port: RTL and testbench

//  Downstream consumer of the CPU OUT-port decode in the invaders top. Latches OUT 3/OUT 5

---
 rtl/invaders_sound_port_pkg.sv | 25 ++
 rtl/invaders_sound_port_sfx_pulse_stretcher.sv | 62 ++++++
 rtl/invaders_sound_port.sv | 100 ++++++++++
 tb/tb_invaders_sound_port.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/invaders_sound_port_pkg.sv
// Shared I/O port numbers, effect indices and pulse-stretcher state type
// for the Space Invaders sound/watchdog output ports.
package invaders_sound_port_pkg;

  localparam logic [7:0] IO_PORT_SOUND1   = 8'h03;
  localparam logic [7:0] IO_PORT_SOUND2   = 8'h05;
  localparam logic [7:0] IO_PORT_WATCHDOG = 8'h06;

  localparam int unsigned SFX_COUNT       = 9;
  localparam int unsigned SFX_SHOT        = 0;
  localparam int unsigned SFX_PLAYER_DIE  = 1;
  localparam int unsigned SFX_INVADER_DIE = 2;
  localparam int unsigned SFX_EXTRA_LIFE  = 3;
  localparam int unsigned SFX_FLEET1      = 4;
  localparam int unsigned SFX_FLEET2      = 5;
  localparam int unsigned SFX_FLEET3      = 6;
  localparam int unsigned SFX_FLEET4      = 7;
  localparam int unsigned SFX_UFO_HIT     = 8;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } pulse_state_e;

endpackage

// File: rtl/invaders_sound_port_sfx_pulse_stretcher.sv
// Turns a single-cycle trigger into a registered start pulse and a
// retriggerable activity window of PULSE_CYCLES cycles.
module sfx_pulse_stretcher
  import invaders_sound_port_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic start,
  output logic active
);

  localparam int unsigned CW = $clog2(PULSE_CYCLES + 1);

  pulse_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      start   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start   <= trig;
    end
  end

  // A trigger while running reloads the count, so the window never gaps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_RUN;
          cnt_d   = CW'(PULSE_CYCLES);
        end
      end
      ST_RUN: begin
        if (trig) begin
          cnt_d = CW'(PULSE_CYCLES);
        end else if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign active = (state_q == ST_RUN);

endmodule

// File: rtl/invaders_sound_port.sv
// OUT 3 / OUT 5 sound latches with rising-edge effect triggers, level sound
// controls, and the OUT 6 watchdog.
module invaders_sound_port
  import invaders_sound_port_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 200000,
  parameter int unsigned WDT_CYCLES   = 2000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           io_addr,
  input  logic [7:0]           io_data,
  input  logic                 write_io,
  output logic                 ufo_loop,
  output logic                 amp_enable,
  output logic [SFX_COUNT-1:0] sfx_start,
  output logic [SFX_COUNT-1:0] sfx_active,
  output logic                 wdt_reset_req
);

  logic [7:0]           port3_q, port5_q;
  logic                 wr3, wr5, kick;
  logic [7:0]           rise3, rise5;
  logic [SFX_COUNT-1:0] trig;
  logic                 unused_latch_bits;

  assign wr3  = write_io && (io_addr == IO_PORT_SOUND1);
  assign wr5  = write_io && (io_addr == IO_PORT_SOUND2);
  assign kick = write_io && (io_addr == IO_PORT_WATCHDOG);

  // Edges compare against the pre-write latch, so a held strobe fires once.
  assign rise3 = {8{wr3}} & io_data & ~port3_q;
  assign rise5 = {8{wr5}} & io_data & ~port5_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      port3_q <= '0;
      port5_q <= '0;
    end else begin
      if (wr3) port3_q <= io_data;
      if (wr5) port5_q <= io_data;
    end
  end

  always_comb begin
    trig                  = '0;
    trig[SFX_SHOT]        = rise3[1];
    trig[SFX_PLAYER_DIE]  = rise3[2];
    trig[SFX_INVADER_DIE] = rise3[3];
    trig[SFX_EXTRA_LIFE]  = rise3[4];
    trig[SFX_FLEET1]      = rise5[0];
    trig[SFX_FLEET2]      = rise5[1];
    trig[SFX_FLEET3]      = rise5[2];
    trig[SFX_FLEET4]      = rise5[3];
    trig[SFX_UFO_HIT]     = rise5[4];
  end

  assign ufo_loop          = port3_q[0];
  assign amp_enable        = port3_q[5];
  assign unused_latch_bits = ^{port3_q[7:6], port5_q[7:5]};

  for (genvar i = 0; i < SFX_COUNT; i++) begin : g_sfx
    sfx_pulse_stretcher #(
      .PULSE_CYCLES(PULSE_CYCLES)
    ) u_stretch (
      .clk   (clk),
      .rst   (rst),
      .trig  (trig[i]),
      .start (sfx_start[i]),
      .active(sfx_active[i])
    );
  end

  if (WDT_CYCLES > 0) begin : g_wdt
    localparam int unsigned WW = $clog2(WDT_CYCLES + 1);
    logic [WW-1:0] wdt_cnt_q;
    logic          wdt_req_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        wdt_cnt_q <= '0;
        wdt_req_q <= 1'b0;
      end else if (kick) begin
        wdt_cnt_q <= '0;
        wdt_req_q <= 1'b0;
      end else if (wdt_cnt_q == WW'(WDT_CYCLES - 1)) begin
        wdt_cnt_q <= '0;
        wdt_req_q <= 1'b1;
      end else begin
        wdt_cnt_q <= wdt_cnt_q + WW'(1);
        wdt_req_q <= 1'b0;
      end
    end

    assign wdt_reset_req = wdt_req_q;
  end else begin : g_no_wdt
    assign wdt_reset_req = 1'b0;
  end

endmodule

// File: tb/tb_invaders_sound_port.sv
// Directed self-checking bench for invaders_sound_port with short pulse and
// watchdog periods.
module tb_invaders_sound_port;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] io_addr;
  logic [7:0] io_data;
  logic       write_io;
  logic       ufo_loop;
  logic       amp_enable;
  logic [8:0] sfx_start;
  logic [8:0] sfx_active;
  logic       wdt_reset_req;

  int n_checks = 0;
  int n_fail   = 0;

  invaders_sound_port #(
    .PULSE_CYCLES(4),
    .WDT_CYCLES  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .io_addr      (io_addr),
    .io_data      (io_data),
    .write_io     (write_io),
    .ufo_loop     (ufo_loop),
    .amp_enable   (amp_enable),
    .sfx_start    (sfx_start),
    .sfx_active   (sfx_active),
    .wdt_reset_req(wdt_reset_req)
  );

  always #5 clk = ~clk;

  // Advance one active edge; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [7:0] a, input logic [7:0] d);
    write_io = w;
    io_addr  = a;
    io_data  = d;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00);
    step();
    step();
    n_checks++;
    if ({ufo_loop, amp_enable, sfx_start, sfx_active, wdt_reset_req} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0",
               {ufo_loop, amp_enable, sfx_start, sfx_active, wdt_reset_req});
    end
    rst = 1'b0;
  endtask

  task automatic test_watchdog_expiry();
    apply_reset();
    for (int k = 1; k <= 33; k++) begin
      step();
      n_checks++;
      if (wdt_reset_req !== ((k % 16) == 0)) begin
        n_fail++;
        $display("FAIL wdt_expiry step %0d: got %b expected %b", k, wdt_reset_req, (k % 16) == 0);
      end
    end
  endtask

  task automatic test_watchdog_kick();
    apply_reset();
    for (int k = 1; k <= 45; k++) begin
      if ((k % 10) == 0) drive(1'b1, 8'h06, 8'h00);
      else               drive(1'b0, 8'h00, 8'h00);
      step();
      n_checks++;
      if (wdt_reset_req !== 1'b0) begin
        n_fail++;
        $display("FAIL wdt_kicked step %0d: got %b expected 0", k, wdt_reset_req);
      end
    end
    drive(1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_one_shot();
    apply_reset();
    drive(1'b1, 8'h03, 8'h02);
    for (int k = 1; k <= 6; k++) begin
      step();
      drive(1'b0, 8'h00, 8'h00);
      n_checks++;
      if (sfx_start !== ((k == 1) ? 9'h001 : 9'h000)) begin
        n_fail++;
        $display("FAIL shot_start step %0d: got %h expected %h", k, sfx_start,
                 (k == 1) ? 9'h001 : 9'h000);
      end
      n_checks++;
      if (sfx_active !== ((k <= 4) ? 9'h001 : 9'h000)) begin
        n_fail++;
        $display("FAIL shot_active step %0d: got %h expected %h", k, sfx_active,
                 (k <= 4) ? 9'h001 : 9'h000);
      end
    end
  endtask

  task automatic test_held_port5();
    logic [8:0] exp_start [1:5];
    exp_start = '{9'h1F0, 9'h000, 9'h000, 9'h000, 9'h010};
    apply_reset();
    for (int k = 1; k <= 5; k++) begin
      if (k <= 3)      drive(1'b1, 8'h05, 8'h1F);
      else if (k == 4) drive(1'b1, 8'h05, 8'h00);
      else             drive(1'b1, 8'h05, 8'h01);
      step();
      n_checks++;
      if (sfx_start !== exp_start[k]) begin
        n_fail++;
        $display("FAIL held5_start step %0d: got %h expected %h", k, sfx_start, exp_start[k]);
      end
    end
    drive(1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) step();
    n_checks++;
    if (sfx_active !== 9'h000) begin
      n_fail++;
      $display("FAIL held5_drain: got %h expected 000", sfx_active);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int k = 1; k <= 10; k++) begin
      if (k == 1 || k == 5) drive(1'b1, 8'h03, 8'h02);
      else if (k == 3)      drive(1'b1, 8'h03, 8'h00);
      else                  drive(1'b0, 8'h00, 8'h00);
      step();
      n_checks++;
      if (sfx_start[0] !== (k == 1 || k == 5)) begin
        n_fail++;
        $display("FAIL retrig_start step %0d: got %b expected %b", k, sfx_start[0],
                 (k == 1 || k == 5));
      end
      n_checks++;
      if (sfx_active[0] !== (k <= 8)) begin
        n_fail++;
        $display("FAIL retrig_active step %0d: got %b expected %b", k, sfx_active[0], k <= 8);
      end
    end
  endtask

  task automatic test_levels();
    apply_reset();
    drive(1'b1, 8'h03, 8'h21);
    step();
    drive(1'b0, 8'h00, 8'h00);
    n_checks++;
    if ({ufo_loop, amp_enable, sfx_start, sfx_active} !== {2'b11, 18'h0}) begin
      n_fail++;
      $display("FAIL levels_on: got %b%b start=%h active=%h expected 11 000 000",
               ufo_loop, amp_enable, sfx_start, sfx_active);
    end
    step();
    n_checks++;
    if ({ufo_loop, amp_enable} !== 2'b11) begin
      n_fail++;
      $display("FAIL levels_hold: got %b%b expected 11", ufo_loop, amp_enable);
    end
    drive(1'b1, 8'h03, 8'h00);
    step();
    drive(1'b0, 8'h00, 8'h00);
    n_checks++;
    if ({ufo_loop, amp_enable} !== 2'b00) begin
      n_fail++;
      $display("FAIL levels_off: got %b%b expected 00", ufo_loop, amp_enable);
    end
  endtask

  task automatic test_reset_mid_window();
    apply_reset();
    drive(1'b1, 8'h03, 8'h23);
    step();
    drive(1'b0, 8'h00, 8'h00);
    step();
    n_checks++;
    if ({ufo_loop, amp_enable, sfx_active[0]} !== 3'b111) begin
      n_fail++;
      $display("FAIL pre_reset: got %b expected 111", {ufo_loop, amp_enable, sfx_active[0]});
    end
    // Reset coincides with a fresh rising write on port 5.
    rst = 1'b1;
    drive(1'b1, 8'h05, 8'h01);
    step();
    rst = 1'b0;
    drive(1'b0, 8'h00, 8'h00);
    n_checks++;
    if ({ufo_loop, amp_enable, sfx_start, sfx_active, wdt_reset_req} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_mid_window: got %h expected 0",
               {ufo_loop, amp_enable, sfx_start, sfx_active, wdt_reset_req});
    end
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, (k[0] ? 8'h04 : 8'h02), 8'hFF);
      step();
      n_checks++;
      if ({ufo_loop, amp_enable, sfx_start, sfx_active, wdt_reset_req} !== 21'h0) begin
        n_fail++;
        $display("FAIL other_ports step %0d: got %h expected 0", k,
                 {ufo_loop, amp_enable, sfx_start, sfx_active, wdt_reset_req});
      end
    end
    // Latches must still be clear, so a port 3 write produces a fresh edge.
    drive(1'b1, 8'h03, 8'h1E);
    step();
    drive(1'b0, 8'h00, 8'h00);
    n_checks++;
    if (sfx_start !== 9'h00F) begin
      n_fail++;
      $display("FAIL post_reset_edge: got %h expected 00f", sfx_start);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00);
    test_reset();
    test_watchdog_expiry();
    test_watchdog_kick();
    test_one_shot();
    test_held_port5();
    test_back_to_back();
    test_levels();
    test_reset_mid_window();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
